// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: next-PC selection, PC write enable, imem request handshake
// and F->D register control, with a one-entry hold buffer for decode back-pressure.
module fetch_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0100,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      pc_cur,
    output logic [31:0]      pc_next,
    output logic             pc_enable,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      f_instr,
    output logic             f2d_enable,
    output logic             f2d_flush,
    input  logic             d_stall,
    input  logic             redir_valid,
    input  logic [31:0]      redir_target,
    input  logic             exc_valid,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [31:0]      hold_r;
    logic [31:0]      hold_nxt_s;
    logic [31:0]      pend_r;
    logic [31:0]      pend_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;

    logic             take_s;
    logic [31:0]      target_s;
    logic             imem_req_s;
    logic             pc_enable_s;
    logic [31:0]      pc_next_s;
    logic [31:0]      f_instr_s;
    logic             f2d_enable_s;
    logic             f2d_flush_s;
    logic             stalling_s;

    // Redirect source selection: exception outranks branch/jump resolution.
    always_comb begin
        take_s = exc_valid | redir_valid;
        if (exc_valid) begin
            target_s = EXC_VECTOR;
        end else begin
            target_s = redir_target;
        end
    end

    // Next-state and same-cycle output decode; outputs follow ack with zero latency.
    always_comb begin
        state_nxt_s  = state_r;
        hold_nxt_s   = hold_r;
        pend_nxt_s   = pend_r;
        imem_req_s   = 1'b0;
        pc_enable_s  = 1'b0;
        pc_next_s    = 32'h0000_0000;
        f_instr_s    = 32'h0000_0000;
        f2d_enable_s = 1'b0;
        f2d_flush_s  = 1'b0;
        if (reset) begin
            // An ack arriving while reset is asserted is dropped entirely.
            state_nxt_s = ST_BOOT;
            hold_nxt_s  = 32'h0000_0000;
            pend_nxt_s  = 32'h0000_0000;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_nxt_s = ST_REQ;
                end
                ST_REQ: begin
                    imem_req_s = 1'b1;
                    if (take_s) begin
                        f2d_flush_s = 1'b1;
                        if (imem_ack) begin
                            pc_enable_s = 1'b1;
                            pc_next_s   = target_s;
                            state_nxt_s = ST_REQ;
                        end else begin
                            // Address must stay stable until the outstanding ack.
                            pend_nxt_s  = target_s;
                            state_nxt_s = ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc_enable_s = 1'b1;
                        pc_next_s   = pc_cur + 32'd4;
                        if (d_stall) begin
                            hold_nxt_s  = imem_rdata;
                            state_nxt_s = ST_HOLD;
                        end else begin
                            f_instr_s    = imem_rdata;
                            f2d_enable_s = 1'b1;
                            state_nxt_s  = ST_REQ;
                        end
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    f_instr_s = hold_r;
                    if (take_s) begin
                        f2d_flush_s = 1'b1;
                        pc_enable_s = 1'b1;
                        pc_next_s   = target_s;
                        hold_nxt_s  = 32'h0000_0000;
                        state_nxt_s = ST_REQ;
                    end else if (!d_stall) begin
                        f2d_enable_s = 1'b1;
                        state_nxt_s  = ST_REQ;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    imem_req_s = 1'b1;
                    if (take_s) begin
                        f2d_flush_s = 1'b1;
                        if (imem_ack) begin
                            pc_enable_s = 1'b1;
                            pc_next_s   = target_s;
                            state_nxt_s = ST_REQ;
                        end else begin
                            pend_nxt_s  = target_s;
                            state_nxt_s = ST_DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc_enable_s = 1'b1;
                        pc_next_s   = pend_r;
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_DRAIN;
                    end
                end
                default: begin
                    state_nxt_s = ST_BOOT;
                end
            endcase
        end
    end

    // State, hold buffer and pending redirect target.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_BOOT;
            hold_r  <= 32'h0000_0000;
            pend_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            hold_r  <= hold_nxt_s;
            pend_r  <= pend_nxt_s;
        end
    end

    assign stalling_s = (state_r == ST_HOLD) || (state_r == ST_DRAIN);

    // Saturating count of cycles spent stalled in HOLD or DRAIN.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stalling_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign imem_req     = imem_req_s;
    assign pc_enable    = pc_enable_s;
    assign pc_next      = pc_next_s;
    assign f_instr      = f_instr_s;
    assign f2d_enable   = f2d_enable_s;
    assign f2d_flush    = f2d_flush_s;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs change on the falling edge, outputs are
// checked 1 ns later against hand-computed values.
module tb_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        pc_enable;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] f_instr;
    logic        f2d_enable;
    logic        f2d_flush;
    logic        d_stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc_valid;
    logic [15:0] stall_cycles;
    logic [3:0]  ctl;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_ctrl #(.EXC_VECTOR(32'h0000_0100), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .pc_cur(pc_cur), .pc_next(pc_next),
        .pc_enable(pc_enable), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .f_instr(f_instr), .f2d_enable(f2d_enable),
        .f2d_flush(f2d_flush), .d_stall(d_stall), .redir_valid(redir_valid),
        .redir_target(redir_target), .exc_valid(exc_valid),
        .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    // {imem_req, pc_enable, f2d_enable, f2d_flush}
    assign ctl = {imem_req, pc_enable, f2d_enable, f2d_flush};

    task automatic test_reset;
        reset = 1'b1; pc_cur = 32'h0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_0000;
        d_stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h40; exc_valid = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        n_vec++; if (ctl !== 4'b0000) begin n_miss++; $display("FAIL rst_ctl got %b want %b", ctl, 4'b0000); end
        n_vec++; if (pc_next !== 32'h0) begin n_miss++; $display("FAIL rst_pc_next got %h want %h", pc_next, 32'h0); end
        n_vec++; if (f_instr !== 32'h0) begin n_miss++; $display("FAIL rst_f_instr got %h want %h", f_instr, 32'h0); end
        n_vec++; if (stall_cycles !== 16'd0) begin n_miss++; $display("FAIL rst_stall got %0d want %0d", stall_cycles, 0); end
        reset = 1'b0;
        #1;
        n_vec++; if (ctl !== 4'b0000) begin n_miss++; $display("FAIL boot_ctl got %b want %b", ctl, 4'b0000); end
        @(negedge clock);
        d_stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;
    endtask

    task automatic test_throughput;
        for (int i = 0; i < 6; i++) begin
            pc_cur = 32'(i * 4); imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(i);
            #1;
            n_vec++; if (ctl !== 4'b1110) begin n_miss++; $display("FAIL thr_ctl[%0d] got %b want %b", i, ctl, 4'b1110); end
            n_vec++; if (pc_next !== 32'((i + 1) * 4)) begin n_miss++; $display("FAIL thr_pc_next[%0d] got %h want %h", i, pc_next, 32'((i + 1) * 4)); end
            n_vec++; if (f_instr !== 32'hA000_0000 + 32'(i)) begin n_miss++; $display("FAIL thr_f_instr[%0d] got %h want %h", i, f_instr, 32'hA000_0000 + 32'(i)); end
            @(negedge clock);
        end
        n_vec++; if (stall_cycles !== 16'd0) begin n_miss++; $display("FAIL thr_stall got %0d want %0d", stall_cycles, 0); end
    endtask

    task automatic test_latency;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                pc_cur = 32'h18 + 32'(k * 4); imem_ack = (c == 2); imem_rdata = 32'h5500_0000 + 32'(k);
                #1;
                if (c == 2) begin
                    n_vec++; if (ctl !== 4'b1110) begin n_miss++; $display("FAIL lat_ack_ctl[%0d] got %b want %b", k, ctl, 4'b1110); end
                    n_vec++; if (pc_next !== 32'h1C + 32'(k * 4)) begin n_miss++; $display("FAIL lat_pc_next[%0d] got %h want %h", k, pc_next, 32'h1C + 32'(k * 4)); end
                end else begin
                    n_vec++; if (ctl !== 4'b1000) begin n_miss++; $display("FAIL lat_wait_ctl[%0d.%0d] got %b want %b", k, c, ctl, 4'b1000); end
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_stall;
        pc_cur = 32'h20; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; d_stall = 1'b1;
        #1;
        n_vec++; if (ctl !== 4'b1100) begin n_miss++; $display("FAIL stl_ack_ctl got %b want %b", ctl, 4'b1100); end
        n_vec++; if (pc_next !== 32'h24) begin n_miss++; $display("FAIL stl_pc_next got %h want %h", pc_next, 32'h24); end
        @(negedge clock);
        pc_cur = 32'h24; imem_ack = 1'b0; imem_rdata = 32'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_vec++; if (ctl !== 4'b0000) begin n_miss++; $display("FAIL stl_hold_ctl[%0d] got %b want %b", c, ctl, 4'b0000); end
            @(negedge clock);
        end
        d_stall = 1'b0;
        #1;
        n_vec++; if (ctl !== 4'b0010) begin n_miss++; $display("FAIL stl_rel_ctl got %b want %b", ctl, 4'b0010); end
        n_vec++; if (f_instr !== 32'hDEAD_BEEF) begin n_miss++; $display("FAIL stl_rel_instr got %h want %h", f_instr, 32'hDEAD_BEEF); end
        @(negedge clock);
        #1;
        n_vec++; if (ctl !== 4'b1000) begin n_miss++; $display("FAIL stl_req_ctl got %b want %b", ctl, 4'b1000); end
        n_vec++; if (stall_cycles !== 16'd3) begin n_miss++; $display("FAIL stl_count got %0d want %0d", stall_cycles, 3); end
    endtask

    task automatic test_redirect;
        pc_cur = 32'h30; imem_ack = 1'b0; redir_valid = 1'b1; redir_target = 32'h40;
        #1;
        n_vec++; if (ctl !== 4'b1001) begin n_miss++; $display("FAIL rdr_ctl got %b want %b", ctl, 4'b1001); end
        @(negedge clock);
        redir_valid = 1'b0; redir_target = 32'h0;
        #1;
        n_vec++; if (ctl !== 4'b1000) begin n_miss++; $display("FAIL rdr_drain_ctl got %b want %b", ctl, 4'b1000); end
        @(negedge clock);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        #1;
        n_vec++; if (ctl !== 4'b1100) begin n_miss++; $display("FAIL rdr_ack_ctl got %b want %b", ctl, 4'b1100); end
        n_vec++; if (pc_next !== 32'h40) begin n_miss++; $display("FAIL rdr_pc_next got %h want %h", pc_next, 32'h40); end
        @(negedge clock);
        pc_cur = 32'h40; imem_ack = 1'b0;
        #1;
        n_vec++; if (ctl !== 4'b1000) begin n_miss++; $display("FAIL rdr_req_ctl got %b want %b", ctl, 4'b1000); end
        n_vec++; if (stall_cycles !== 16'd5) begin n_miss++; $display("FAIL rdr_count got %0d want %0d", stall_cycles, 5); end
    endtask

    task automatic test_exc_priority;
        pc_cur = 32'h44; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        exc_valid = 1'b1; redir_valid = 1'b1; redir_target = 32'h80;
        #1;
        n_vec++; if (ctl !== 4'b1101) begin n_miss++; $display("FAIL exc_ctl got %b want %b", ctl, 4'b1101); end
        n_vec++; if (pc_next !== 32'h100) begin n_miss++; $display("FAIL exc_pc_next got %h want %h", pc_next, 32'h100); end
        @(negedge clock);
        // Redirect into DRAIN, overwrite the pending target, then exc+redir with ack.
        pc_cur = 32'h100; imem_ack = 1'b0; exc_valid = 1'b0; redir_valid = 1'b1; redir_target = 32'h40;
        @(negedge clock);
        redir_target = 32'h80;
        #1;
        n_vec++; if (ctl !== 4'b1001) begin n_miss++; $display("FAIL drn_over_ctl got %b want %b", ctl, 4'b1001); end
        @(negedge clock);
        exc_valid = 1'b1; redir_target = 32'h300; imem_ack = 1'b1;
        #1;
        n_vec++; if (pc_next !== 32'h100) begin n_miss++; $display("FAIL drn_exc_pc_next got %h want %h", pc_next, 32'h100); end
        @(negedge clock);
        exc_valid = 1'b0; redir_valid = 1'b0; redir_target = 32'h0;
        imem_ack = 1'b1; d_stall = 1'b1; imem_rdata = 32'h22;
        @(negedge clock);
        imem_ack = 1'b0; redir_valid = 1'b1; redir_target = 32'h200;
        #1;
        n_vec++; if (ctl !== 4'b0101) begin n_miss++; $display("FAIL hold_rdr_ctl got %b want %b", ctl, 4'b0101); end
        n_vec++; if (pc_next !== 32'h200) begin n_miss++; $display("FAIL hold_rdr_pc_next got %h want %h", pc_next, 32'h200); end
        @(negedge clock);
        redir_valid = 1'b0; redir_target = 32'h0; d_stall = 1'b0;
        #1;
        n_vec++; if (stall_cycles !== 16'd8) begin n_miss++; $display("FAIL exc_count got %0d want %0d", stall_cycles, 8); end
    endtask

    task automatic test_reset_mid;
        pc_cur = 32'h50; imem_ack = 1'b0; redir_valid = 1'b1; redir_target = 32'h40;
        @(negedge clock);
        redir_valid = 1'b0; reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h33;
        #1;
        n_vec++; if (ctl !== 4'b0000) begin n_miss++; $display("FAIL rdrn_ctl got %b want %b", ctl, 4'b0000); end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_vec++; if (ctl !== 4'b0000) begin n_miss++; $display("FAIL rdrn_boot_ctl got %b want %b", ctl, 4'b0000); end
        n_vec++; if (stall_cycles !== 16'd0) begin n_miss++; $display("FAIL rdrn_count got %0d want %0d", stall_cycles, 0); end
        @(negedge clock);
        pc_cur = 32'h8; d_stall = 1'b1; imem_rdata = 32'h44;
        @(negedge clock);
        reset = 1'b1; d_stall = 1'b0; imem_ack = 1'b0;
        #1;
        n_vec++; if ({ctl, f_instr} !== {4'b0000, 32'h0}) begin n_miss++; $display("FAIL rhld_out got %b/%h want %b/%h", ctl, f_instr, 4'b0000, 32'h0); end
        @(negedge clock);
        reset = 1'b0; imem_ack = 1'b1;
        #1;
        n_vec++; if ({ctl, f_instr} !== {4'b0000, 32'h0}) begin n_miss++; $display("FAIL rhld_boot got %b/%h want %b/%h", ctl, f_instr, 4'b0000, 32'h0); end
        @(negedge clock);
        pc_cur = 32'hFFFF_FFFC; imem_rdata = 32'h55;
        #1;
        n_vec++; if (ctl !== 4'b1110) begin n_miss++; $display("FAIL wrap_ctl got %b want %b", ctl, 4'b1110); end
        n_vec++; if (pc_next !== 32'h0) begin n_miss++; $display("FAIL wrap_pc_next got %h want %h", pc_next, 32'h0); end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_throughput();
        test_latency();
        test_stall();
        test_redirect();
        test_exc_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
